// File: rtl/pipelined_adder.sv
// Carry-chained, valid/ready pipelined adder/subtractor: STAGES slices of WIDTH/STAGES bits,
// skewed operands in and deskewed partial sums out, so every result leaves as one word.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int SW = WIDTH / STAGES;

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_carry;
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic              r_ov;

    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_upv;
    logic [STAGES-1:0] w_en;
    logic [STAGES-1:0] w_cin;
    logic [STAGES-1:0] w_cout;
    logic [WIDTH-1:0]  w_a    [STAGES];
    logic [WIDTH-1:0]  w_b    [STAGES];
    logic [WIDTH-1:0]  w_snew [STAGES];
    logic [SW:0]       w_slice[STAGES];
    logic              w_ov;

    // A stage can take new data when it is empty or the stage after it can take its data;
    // resolved from the output end backwards so bubbles collapse in one cycle.
    always_comb begin
        w_load = '0;
        w_upv  = '0;
        w_load[STAGES-1] = !r_valid[STAGES-1] || out_ready;
        for (int unsigned i = 1; i < STAGES; i++) begin
            w_load[STAGES-1-i] = !r_valid[STAGES-1-i] || w_load[STAGES-i];
        end
        w_upv[0] = in_valid;
        for (int unsigned i = 1; i < STAGES; i++) begin
            w_upv[i] = r_valid[i-1];
        end
        w_en = w_load & w_upv;
    end

    always_comb begin
        w_ov = 1'b0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            w_a[i]     = '0;
            w_b[i]     = '0;
            w_snew[i]  = '0;
            w_cin[i]   = 1'b0;
            w_slice[i] = '0;
            w_cout[i]  = 1'b0;
        end
        w_a[0]   = data_A;
        w_b[0]   = sub ? ~data_B : data_B;
        w_cin[0] = carry_in ^ sub;
        for (int unsigned i = 1; i < STAGES; i++) begin
            w_a[i]    = r_a[i-1];
            w_b[i]    = r_b[i-1];
            w_cin[i]  = r_carry[i-1];
            w_snew[i] = r_s[i-1];
        end
        for (int unsigned i = 0; i < STAGES; i++) begin
            w_slice[i] = {1'b0, w_a[i][i*SW +: SW]} + {1'b0, w_b[i][i*SW +: SW]}
                       + {{SW{1'b0}}, w_cin[i]};
            w_snew[i][i*SW +: SW] = w_slice[i][SW-1:0];
            w_cout[i] = w_slice[i][SW];
        end
        // Carry into the MSB recovered from the MSB sum bit and its operand bits.
        w_ov = w_a[STAGES-1][WIDTH-1] ^ w_b[STAGES-1][WIDTH-1]
             ^ w_slice[STAGES-1][SW-1] ^ w_slice[STAGES-1][SW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_carry <= '0;
            r_ov    <= 1'b0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
                r_s[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= w_upv[i];
                end
                if (w_en[i]) begin
                    r_a[i]     <= w_a[i];
                    r_b[i]     <= w_b[i];
                    r_s[i]     <= w_snew[i];
                    r_carry[i] <= w_cout[i];
                end
            end
            if (w_en[STAGES-1]) begin
                r_ov <= w_ov;
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign carry_out = r_carry[STAGES-1];
    assign overflow  = r_ov;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed + randomized bench for pipelined_adder; expected results come from signed/unsigned
// integer arithmetic on the operands, queued in acceptance order.
module tb_pipelined_adder;
    localparam int W = 32;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_A;
    logic [W-1:0] data_B;
    logic         carry_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    res_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   nacc     = 0;
    int   nout     = 0;
    int   first_pop = -1;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_A(data_A), .data_B(data_B), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .carry_out(carry_out), .overflow(overflow)
    );

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
        longint ua, ub, sa, sbv, lc, e, full, maxs, mins;
        res_t r;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        lc   = longint'(ci);
        maxs = (longint'(1) <<< (W-1)) - 1;
        mins = -(longint'(1) <<< (W-1));
        if (sb) begin
            full = ua - ub - lc;
            e    = sa - sbv - lc;
            r.c  = (full >= 0);
        end else begin
            full = ua + ub + lc;
            e    = sa + sbv + lc;
            r.c  = (full >= (longint'(1) <<< W));
        end
        r.s = W'(full);
        r.v = (e > maxs) || (e < mins);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sb, input logic ordy, input logic r);
        res_t e;
        rst       = r;
        in_valid  = iv;
        data_A    = a;
        data_B    = b;
        carry_in  = ci;
        sub       = sb;
        out_ready = ordy;
        #1;
        if (r) begin
            q.delete();
        end else begin
            chk("in_ready_vs_occupancy", 64'(in_ready), 64'((q.size() < S) || ordy));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_output", 64'(out_valid), 64'(0));
                end else begin
                    chk("result", 64'({sum, carry_out, overflow}), 64'(q[0]));
                    if (ordy) begin
                        e = q.pop_front();
                        nout++;
                        if (first_pop < 0) first_pop = cyc;
                    end
                end
            end
            if (iv && in_ready) begin
                q.push_back(model(a, b, ci, sb));
                nacc++;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    task automatic check_idle(input string tag);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_sum"},       64'(sum),       64'(0));
        chk({tag, "_carry_out"}, 64'(carry_out), 64'(0));
        chk({tag, "_overflow"},  64'(overflow),  64'(0));
        chk({tag, "_in_ready"},  64'(in_ready),  64'(1));
    endtask

    initial begin
        int c0, a0, o0, g;

        // reset
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_idle("reset");

        // full carry ripple, latency
        c0 = cyc;
        first_pop = -1;
        cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < S + 2; i++) idle(1'b1);
        chk("latency", 64'(first_pop - c0), 64'(S));

        // subtraction corner cases
        cycle(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < S + 1; i++) idle(1'b1);
        chk("sub_drained", 64'(q.size()), 64'(0));

        // 100 back-to-back random operations
        o0 = nout;
        for (int i = 0; i < 100; i++)
            cycle(1'b1, $urandom, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 1'b1, 1'b0);
        for (int i = 0; i < S; i++) idle(1'b1);
        chk("stream_count", 64'(nout - o0), 64'(100));

        // backpressure: exactly S accepted, first result held while stalled
        a0 = nacc;
        cycle(1'b1, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < S + 3; i++)
            cycle(1'b1, $urandom, $urandom, 1'b0, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
        chk("bp_accepts", 64'(nacc - a0), 64'(S));
        o0 = nout;
        for (int i = 0; i < S + 1; i++) idle(1'b1);
        chk("bp_drained", 64'(nout - o0), 64'(S));

        // random handshake toggling, 1000 operations
        a0 = nacc;
        g = 0;
        while ((nacc - a0) < 1000 && g < 8000) begin
            cycle($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);
            g++;
        end
        chk("random_accepts", 64'(nacc - a0), 64'(1000));
        g = 0;
        while (q.size() > 0 && g < 50) begin
            idle(1'b1);
            g++;
        end
        chk("random_drained", 64'(q.size()), 64'(0));

        // mid-flight reset discards three operations
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'hDEAD_0000 + 32'(i), 32'h0000_1111, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 1'b1);
        check_idle("midreset");
        for (int i = 0; i < 12; i++) idle(1'b1);
        cycle(1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < S + 1; i++) idle(1'b1);
        chk("post_reset_drained", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
